// File: rtl/timestamp_readout_if.sv
// Byte stream from the timestamp readout to the USB byte FIFO.
// A byte moves on any clock edge where oTxValid and iTxReady are both high.
interface timestamp_readout_if;
    logic [7:0] oTxData;
    logic       oTxValid;
    logic       iTxReady;

    modport master (output oTxData, output oTxValid, input  iTxReady);
    modport slave  (input  oTxData, input  oTxValid, output iTxReady);
endinterface

// File: rtl/timestamp_readout.sv
// Snapshots a ready timestamp register, pulses its latch reset and streams a 13-byte record.
// First byte comes pSETTLE+3 cycles after a ready edge; a stalled byte is held until iTxReady accepts it.
module timestamp_readout #(
    parameter int pSETTLE = 2,
    parameter int pPHASEW = 26
) (
    input  logic        globalClock,
    input  logic        iReset,
    input  logic [31:0] i1COUNTER,
    input  logic [31:0] i1COUNTERHi,
    input  logic [31:0] i1COUNTERPhase,
    input  logic        iRdyCOUNTER,
    input  logic [31:0] i2COUNTER,
    input  logic [31:0] i2COUNTERHi,
    input  logic [31:0] i2COUNTERPhase,
    input  logic        iRdyCOUNTER2,
    output logic        oResetLatch1,
    output logic        oResetLatch2,
    output logic        oBusy,
    output logic [6:0]  oSeq,
    timestamp_readout_if.master tx
);

    localparam int CW = (pSETTLE > 1) ? $clog2(pSETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(pSETTLE - 1);
    localparam logic [32:0]   PH_ONE      = 33'h1 << pPHASEW;
    localparam logic [31:0]   PHASE_MASK  = 32'(PH_ONE - 33'h1);
    localparam logic [3:0]    LAST_BYTE   = 4'd12;

    typedef enum logic [1:0] {IDLE, SETTLE, SEND, DRAIN} state_t;

    state_t      state_q, state_d;
    logic        rdy1_m, rdy1_s, rdy2_m, rdy2_s;
    logic        sel_q, sel_d;
    logic        last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [95:0] buf_q, buf_d;
    logic [3:0]  idx_q, idx_d;
    logic [6:0]  seq_q, seq_d;
    logic        rl1_q, rl1_d, rl2_q, rl2_d;
    logic [7:0]  tx_byte;
    logic        xfer;

    // Ready flags come from the counter's clock domain.
    always_ff @(posedge globalClock or posedge iReset) begin
        if (iReset) begin
            rdy1_m <= 1'b0;
            rdy1_s <= 1'b0;
            rdy2_m <= 1'b0;
            rdy2_s <= 1'b0;
        end else begin
            rdy1_m <= iRdyCOUNTER;
            rdy1_s <= rdy1_m;
            rdy2_m <= iRdyCOUNTER2;
            rdy2_s <= rdy2_m;
        end
    end

    always_ff @(posedge globalClock or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
            seq_q   <= '0;
            rl1_q   <= 1'b0;
            rl2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            rl1_q   <= rl1_d;
            rl2_q   <= rl2_d;
        end
    end

    assign xfer = (state_q == SEND) && tx.iTxReady;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        rl1_d   = rl1_q;
        rl2_d   = rl2_q;

        // Latch reset is held until the counter shows it has cleared its flag.
        if (rl1_q && !rdy1_s) rl1_d = 1'b0;
        if (rl2_q && !rdy2_s) rl2_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rdy1_s || rdy2_s) begin
                    sel_d   = (rdy1_s && rdy2_s) ? ~last_q : rdy2_s;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    if (sel_q) begin
                        buf_d = {i2COUNTERPhase & PHASE_MASK, i2COUNTERHi, i2COUNTER};
                        rl2_d = 1'b1;
                    end else begin
                        buf_d = {i1COUNTERPhase & PHASE_MASK, i1COUNTERHi, i1COUNTER};
                        rl1_d = 1'b1;
                    end
                    last_d  = sel_q;
                    idx_d   = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_BYTE) begin
                        seq_d   = seq_q + 7'd1;
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                // Wait for a fresh latch so the same channel is never sampled twice.
                if (sel_q ? (!rl2_q && !rdy2_s) : (!rl1_q && !rdy1_s))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_byte = {sel_q, seq_q};
        for (int i = 1; i < 13; i++) begin
            if (idx_q == 4'(i)) tx_byte = buf_q[(i-1)*8 +: 8];
        end
    end

    assign tx.oTxValid  = (state_q == SEND);
    assign tx.oTxData   = (state_q == SEND) ? tx_byte : 8'h00;
    assign oResetLatch1 = rl1_q;
    assign oResetLatch2 = rl2_q;
    assign oBusy        = (state_q != IDLE);
    assign oSeq         = seq_q;

    a_latch_excl: assert property (@(posedge globalClock) disable iff (iReset)
        !(oResetLatch1 && oResetLatch2));
    a_data_hold: assert property (@(posedge globalClock) disable iff (iReset)
        (tx.oTxValid && !tx.iTxReady) |=> $stable(tx.oTxData));

endmodule
